// File: rtl/ring_seq_if.sv
// Observation bus of the ring-counter sequence checker: sampled code in,
// decoded position, lock status and error reporting out.
interface ring_seq_if #(
  parameter int ERR_W = 8
);
  logic             valid;
  logic [3:0]       q_in;
  logic [2:0]       idx;
  logic             code_ok;
  logic             locked;
  logic             seq_err;
  logic             wrap;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output valid, q_in,
    input  idx, code_ok, locked, seq_err, wrap, err_cnt
  );

  modport slave (
    input  valid, q_in,
    output idx, code_ok, locked, seq_err, wrap, err_cnt
  );
endinterface

// File: rtl/ring_seq_checker.sv
// Watches a 5-state one-hot-or-zero ring counter, locks after LOCK_N clean
// advances and reports/counts sequence violations while locked.
module ring_seq_checker #(
  parameter int ERR_W  = 8,
  parameter int LOCK_N = 5
) (
  input logic       Clk,
  input logic       resetn,
  ring_seq_if.slave bus
);

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    LOCK  = 2'd2
  } state_t;

  localparam logic [3:0]       LOCK_N_C  = 4'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX_C = {ERR_W{1'b1}};

  function automatic logic [2:0] code_to_idx(input logic [3:0] code);
    case (code)
      4'b0000: code_to_idx = 3'd0;
      4'b1000: code_to_idx = 3'd1;
      4'b0100: code_to_idx = 3'd2;
      4'b0010: code_to_idx = 3'd3;
      4'b0001: code_to_idx = 3'd4;
      default: code_to_idx = 3'd7;
    endcase
  endfunction

  // An out-of-ring successor (1111) can never match a legal sample.
  function automatic logic [3:0] succ_of(input logic [3:0] code);
    case (code)
      4'b0000: succ_of = 4'b1000;
      4'b1000: succ_of = 4'b0100;
      4'b0100: succ_of = 4'b0010;
      4'b0010: succ_of = 4'b0001;
      4'b0001: succ_of = 4'b0000;
      default: succ_of = 4'b1111;
    endcase
  endfunction

  state_t           state_r, state_nxt_s;
  logic [3:0]       prev_r, prev_nxt_s;
  logic [3:0]       adv_cnt_r, adv_cnt_nxt_s;
  logic [2:0]       idx_r;
  logic             code_ok_r;
  logic             seq_err_r;
  logic             wrap_r;
  logic [ERR_W-1:0] err_cnt_r;

  logic [2:0] samp_idx_s;
  logic       legal_s, hold_s, adv_s, viol_s;
  logic       err_pulse_s, wrap_pulse_s;
  logic [3:0] adv_inc_s;

  // Classify the current sample against the previously accepted code.
  always_comb begin
    samp_idx_s = code_to_idx(bus.q_in);
    legal_s    = (samp_idx_s != 3'd7);
    hold_s     = legal_s && (bus.q_in == prev_r);
    adv_s      = legal_s && (bus.q_in == succ_of(prev_r));
    viol_s     = !(hold_s || adv_s);
    adv_inc_s  = adv_cnt_r + 4'd1;
  end

  // Next-state and pulse decode for the HUNT/TRACK/LOCK machine.
  always_comb begin
    state_nxt_s   = state_r;
    prev_nxt_s    = prev_r;
    adv_cnt_nxt_s = adv_cnt_r;
    err_pulse_s   = 1'b0;
    wrap_pulse_s  = 1'b0;
    if (bus.valid) begin
      case (state_r)
        HUNT: begin
          if (bus.q_in == 4'b0000) begin
            state_nxt_s   = TRACK;
            prev_nxt_s    = 4'b0000;
            adv_cnt_nxt_s = 4'd0;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        TRACK: begin
          if (viol_s) begin
            state_nxt_s = HUNT;
          end else if (adv_s) begin
            prev_nxt_s    = bus.q_in;
            adv_cnt_nxt_s = adv_inc_s;
            if (adv_inc_s == LOCK_N_C) begin
              state_nxt_s = LOCK;
            end else begin
              state_nxt_s = TRACK;
            end
          end else begin
            state_nxt_s = TRACK;
          end
        end
        LOCK: begin
          if (viol_s) begin
            state_nxt_s = HUNT;
            err_pulse_s = 1'b1;
          end else if (adv_s) begin
            prev_nxt_s   = bus.q_in;
            wrap_pulse_s = (prev_r == 4'b0001);
          end else begin
            state_nxt_s = LOCK;
          end
        end
        default: begin
          state_nxt_s = HUNT;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, history and registered outputs.
  always_ff @(posedge Clk or negedge resetn) begin
    if (!resetn) begin
      state_r   <= HUNT;
      prev_r    <= 4'b0000;
      adv_cnt_r <= 4'd0;
      idx_r     <= 3'd0;
      code_ok_r <= 1'b0;
      seq_err_r <= 1'b0;
      wrap_r    <= 1'b0;
      err_cnt_r <= '0;
    end else begin
      state_r   <= state_nxt_s;
      prev_r    <= prev_nxt_s;
      adv_cnt_r <= adv_cnt_nxt_s;
      seq_err_r <= err_pulse_s;
      wrap_r    <= wrap_pulse_s;
      if (bus.valid) begin
        idx_r     <= samp_idx_s;
        code_ok_r <= legal_s;
      end
      if (err_pulse_s && (err_cnt_r != ERR_MAX_C)) begin
        err_cnt_r <= err_cnt_r + {{(ERR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.idx     = idx_r;
  assign bus.code_ok = code_ok_r;
  assign bus.locked  = (state_r == LOCK);
  assign bus.seq_err = seq_err_r;
  assign bus.wrap    = wrap_r;
  assign bus.err_cnt = err_cnt_r;

endmodule

// File: tb/tb_ring_seq_checker.sv
// Self-checking bench: directed table, corner-case sequences and random
// stimulus against a position-arithmetic reference model; two DUT widths.
module tb_ring_seq_checker;

  localparam int LOCK_N = 5;
  localparam logic [3:0] CODES [5] = '{4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};

  logic Clk;
  logic resetn;

  ring_seq_if #(.ERR_W(8)) bus_a ();
  ring_seq_if #(.ERR_W(2)) bus_b ();

  ring_seq_checker #(.ERR_W(8), .LOCK_N(LOCK_N)) u_dut_a (
    .Clk(Clk), .resetn(resetn), .bus(bus_a)
  );
  ring_seq_checker #(.ERR_W(2), .LOCK_N(LOCK_N)) u_dut_b (
    .Clk(Clk), .resetn(resetn), .bus(bus_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0=hunt 1=track 2=lock; positions 0..4 on the ring.
  int m_mode, m_prev, m_cnt, m_errs, m_idx;
  logic m_ok, m_err, m_wrap;

  function automatic int pos_of(input logic [3:0] c);
    for (int i = 0; i < 5; i++) if (CODES[i] == c) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_cnt = 0; m_errs = 0;
    m_idx = 0; m_ok = 1'b0; m_err = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [3:0] c);
    int p;
    bit hold, adv;
    m_err = 1'b0;
    m_wrap = 1'b0;
    if (v) begin
      p = pos_of(c);
      m_idx = (p < 0) ? 7 : p;
      m_ok = (p >= 0);
      if (m_mode == 0) begin
        if (p == 0) begin m_mode = 1; m_prev = 0; m_cnt = 0; end
      end else begin
        hold = (p == m_prev);
        adv  = (p >= 0) && (p == (m_prev + 1) % 5);
        if (!hold && !adv) begin
          if (m_mode == 2) begin m_err = 1'b1; m_errs++; end
          m_mode = 0;
        end else if (adv) begin
          if (m_mode == 2 && m_prev == 4) m_wrap = 1'b1;
          m_prev = p;
          if (m_mode == 1) begin
            m_cnt++;
            if (m_cnt == LOCK_N) m_mode = 2;
          end
        end
      end
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " idx"}, int'(bus_a.idx), m_idx);
    chk({tag, " code_ok"}, int'(bus_a.code_ok), int'(m_ok));
    chk({tag, " locked"}, int'(bus_a.locked), int'(m_mode == 2));
    chk({tag, " seq_err"}, int'(bus_a.seq_err), int'(m_err));
    chk({tag, " wrap"}, int'(bus_a.wrap), int'(m_wrap));
    chk({tag, " err_cnt8"}, int'(bus_a.err_cnt), (m_errs > 255) ? 255 : m_errs);
    chk({tag, " err_cnt2"}, int'(bus_b.err_cnt), (m_errs > 3) ? 3 : m_errs);
    chk({tag, " locked2"}, int'(bus_b.locked), int'(m_mode == 2));
  endtask

  task automatic drive(input logic v, input logic [3:0] q);
    bus_a.valid = v; bus_a.q_in = q;
    bus_b.valid = v; bus_b.q_in = q;
    @(posedge Clk);
    model_step(v, q);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic v, input logic [3:0] q);
    drive(v, q);
    check_model(tag);
  endtask

  task automatic go_lock(input string tag);
    for (int i = 0; i <= 5; i++) step_chk(tag, 1'b1, CODES[i % 5]);
    chk({tag, " reached lock"}, int'(bus_a.locked), 1);
  endtask

  typedef struct {
    logic       v;
    logic [3:0] q;
    int         e_idx;
    logic       e_ok;
    logic       e_lock;
    logic       e_err;
    logic       e_wrap;
  } vec_t;

  vec_t tbl [15];

  initial begin
    int gen_pos;
    int r;
    logic [3:0] q;
    logic v;

    tbl[0]  = '{1'b1, 4'b0000, 0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'b1000, 1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'b0100, 2, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 4'b0010, 3, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'b0001, 4, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 4'b0000, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 4'b1000, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 4'b0100, 2, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 4'b0010, 3, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 4'b0001, 4, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'b0000, 0, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[11] = '{1'b1, 4'b0000, 0, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'b1000, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 4'b0010, 3, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0001, 3, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset state, checked asynchronously and again after clock edges
    bus_a.valid = 1'b0; bus_a.q_in = 4'b0000;
    bus_b.valid = 1'b0; bus_b.q_in = 4'b0000;
    resetn = 1'b1;
    model_reset();
    #2 resetn = 1'b0;
    #1 check_model("reset_async");
    @(posedge Clk); @(posedge Clk); #1;
    check_model("reset_held");
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].q);
      chk($sformatf("tbl%0d idx", i), int'(bus_a.idx), tbl[i].e_idx);
      chk($sformatf("tbl%0d code_ok", i), int'(bus_a.code_ok), int'(tbl[i].e_ok));
      chk($sformatf("tbl%0d locked", i), int'(bus_a.locked), int'(tbl[i].e_lock));
      chk($sformatf("tbl%0d seq_err", i), int'(bus_a.seq_err), int'(tbl[i].e_err));
      chk($sformatf("tbl%0d wrap", i), int'(bus_a.wrap), int'(tbl[i].e_wrap));
      chk($sformatf("tbl%0d err_cnt", i), int'(bus_a.err_cnt), m_errs);
    end
    chk("tbl err_cnt after one violation", int'(bus_a.err_cnt), 1);

    // Illegal code in LOCK, then the same code in TRACK
    go_lock("lock_a");
    step_chk("illegal_lock", 1'b1, 4'b1100);
    chk("illegal_lock idx", int'(bus_a.idx), 7);
    chk("illegal_lock seq_err", int'(bus_a.seq_err), 1);
    chk("illegal_lock locked", int'(bus_a.locked), 0);
    step_chk("track_in", 1'b1, 4'b0000);
    step_chk("track_adv", 1'b1, 4'b1000);
    step_chk("illegal_track", 1'b1, 4'b1100);
    chk("illegal_track seq_err", int'(bus_a.seq_err), 0);
    step_chk("hunt_ignore", 1'b1, 4'b1000);

    // A violating 0000 in LOCK goes to HUNT; only the next 0000 starts TRACK
    go_lock("lock_b");
    step_chk("lock_b adv", 1'b1, 4'b1000);
    step_chk("viol_zero", 1'b1, 4'b0000);
    chk("viol_zero seq_err", int'(bus_a.seq_err), 1);
    step_chk("viol_zero hunt", 1'b1, 4'b1000);
    go_lock("lock_c");

    // Long hold plus valid gap stays locked
    step_chk("hold_pre1", 1'b1, 4'b1000);
    step_chk("hold_pre2", 1'b1, 4'b0100);
    for (int i = 0; i < 10; i++) step_chk("hold_rep", 1'b1, 4'b0100);
    for (int i = 0; i < 5; i++) step_chk("gap", 1'b0, 4'b1111);
    step_chk("after_gap", 1'b1, 4'b0010);
    chk("after_gap locked", int'(bus_a.locked), 1);
    chk("after_gap seq_err", int'(bus_a.seq_err), 0);
    step_chk("leave_lock", 1'b1, 4'b0100);

    // Saturation of the narrow counter, then reset mid-TRACK
    for (int k = 0; k < 5; k++) begin
      go_lock("sat_lock");
      step_chk("sat_viol", 1'b1, 4'b0110);
    end
    chk("sat err_cnt2", int'(bus_b.err_cnt), 3);
    chk("sat seq_err", int'(bus_b.seq_err), 1);
    step_chk("rst_track0", 1'b1, 4'b0000);
    step_chk("rst_track1", 1'b1, 4'b1000);
    #3 resetn = 1'b0;
    model_reset();
    #1 check_model("midreset");
    chk("midreset err_cnt2", int'(bus_b.err_cnt), 0);
    @(posedge Clk); #1 resetn = 1'b1;
    step_chk("post_rst1", 1'b1, 4'b0100);
    step_chk("post_rst2", 1'b1, 4'b0010);
    go_lock("post_rst_lock");

    // Random stimulus against the model
    gen_pos = 0;
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        gen_pos = (gen_pos + 1) % 5;
        q = CODES[gen_pos];
      end else if (r <= 7) begin
        q = CODES[gen_pos];
      end else if (r == 8) begin
        q = 4'($urandom_range(0, 15));
      end else begin
        gen_pos = $urandom_range(0, 4);
        q = CODES[gen_pos];
      end
      v = ($urandom_range(0, 4) != 0);
      step_chk("rand", v, q);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
